// File: rtl/rce_encode_sequencer.sv
// Single-clock control sequencer for the parallel RCE encoder: gates serial message
// loading, strobes the encoding units per chunk, then drives the parity transmit phase.
module rce_encode_sequencer #(
  parameter int K      = 1024,
  parameter int K_N    = 256,
  parameter int LMLA   = 256,
  parameter int NCHUNK = 4,
  parameter int FSEL_W = 2,
  parameter int BCNT_W = 8,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              datavalid,
  output logic              ready,
  output logic              sm,
  output logic              acc_clr,
  output logic              en,
  output logic [FSEL_W-1:0] f_sel,
  output logic              p_en,
  output logic              t_en,
  output logic              done,
  output logic              overrun_err
);

  // The last chunk index follows the message length, bounded by the f_sel range.
  localparam int LAST_CHUNK = ((K / LMLA) < NCHUNK) ? (K / LMLA) - 1 : NCHUNK - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_ENC,
    S_PLOAD,
    S_PTX,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FSEL_W-1:0]   chunk_q, chunk_d;
  logic [PCNT_W-1:0]   p_cnt_q, p_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      chunk_q   <= '0;
      p_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      chunk_q   <= chunk_d;
      p_cnt_q   <= p_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    chunk_d   = chunk_q;
    p_cnt_d   = p_cnt_q;
    ready     = 1'b0;
    sm        = 1'b0;
    acc_clr   = 1'b0;
    en        = 1'b0;
    p_en      = 1'b0;
    t_en      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        acc_clr   = 1'b1;
        bit_cnt_d = '0;
        chunk_d   = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        sm = datavalid;
        if (datavalid) begin
          if (bit_cnt_q == BCNT_W'(LMLA - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_ENC;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_ENC: begin
        en = 1'b1;
        // chunk stays at its final value through the parity phase so f_sel is stable.
        if (chunk_q == FSEL_W'(LAST_CHUNK)) begin
          state_d = S_PLOAD;
        end else begin
          chunk_d = chunk_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_PLOAD: begin
        p_en    = 1'b1;
        p_cnt_d = '0;
        state_d = S_PTX;
      end
      S_PTX: begin
        t_en = 1'b1;
        if (p_cnt_q == PCNT_W'(K_N - 1)) begin
          p_cnt_d = '0;
          state_d = S_DONE;
        end else begin
          p_cnt_d = p_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        chunk_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign f_sel = chunk_q;
  // A valid bit anywhere but LOAD is dropped; flag it so upstream can detect the loss.
  assign overrun_err = datavalid && (state_q != S_LOAD);

endmodule

// File: doc/rce_encode_sequencer.md
Name: rce_encode_sequencer

Overview:
- Single-clock sequencer for the parallel RCE encoder datapath.
- Gates serial message acceptance, strobes the encoding units once per LMLA-bit chunk, and steps the function-generator select (f_sel) across chunks.
- After the last chunk: loads the parity shifter, holds the transmit mux on parity for K_N cycles, then pulses done.
- Replaces the split-clock FSM so the whole encoder runs from one clock.

Parameters:
- K, 1024, message length in bits.
- K_N, 256, parity length in bits (parity shifter depth).
- LMLA, 256, message bits per encode chunk (M*La).
- NCHUNK, 4, chunks per codeword (K/LMLA).
- FSEL_W, 2, f_sel width (log2 NCHUNK).
- BCNT_W, 8, bit-counter width (log2 LMLA).
- PCNT_W, 8, parity-counter width (log2 K_N).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle codeword request, honoured only in IDLE.
- datavalid  input  1  a serial message bit is present this cycle.
- ready  output  1  sequencer is IDLE and accepts start.
- sm  output  1  message shift enable; = datavalid while in LOAD, else 0.
- acc_clr  output  1  clears the encoding-unit accumulators; one cycle.
- en  output  1  encode strobe to all encoding units; one cycle per chunk.
- f_sel  output  FSEL_W  function-generator select = current chunk index.
- p_en  output  1  parity parallel-load strobe to the parity shifter.
- t_en  output  1  transmit mux select; 1 = parity, 0 = message.
- done  output  1  one-cycle end-of-codeword pulse.
- overrun_err  output  1  one-cycle pulse when datavalid=1 outside LOAD.

Behaviour:
- Moore FSM with registered state, bit_cnt, chunk (drives f_sel) and p_cnt. All outputs decode from registered state, except sm and overrun_err, which also use datavalid.
- Reset (rst=1 at a clock edge, any state, including mid-codeword):
  - state=IDLE; bit_cnt=0, chunk=0, p_cnt=0.
  - Next cycle: ready=1; sm, acc_clr, en, p_en, t_en, done=0; f_sel=0.
  - Any partial codeword is abandoned.
- IDLE: ready=1.
  - start=1 -> CLR.
  - datavalid=1 -> overrun_err pulse, bit ignored.
- CLR (1 cycle): acc_clr=1; bit_cnt=0, chunk=0 -> LOAD.
  - First bit can be accepted 2 cycles after start.
- LOAD: sm=datavalid.
  - Each datavalid increments bit_cnt; idle cycles (datavalid=0) hold all state.
  - datavalid=1 with bit_cnt=LMLA-1: bit accepted, bit_cnt wraps to 0 -> ENC.
- ENC (1 cycle): en=1, f_sel=chunk, sm=0.
  - chunk<NCHUNK-1: chunk+1 -> LOAD.
  - chunk=NCHUNK-1: -> PLOAD, chunk held until IDLE.
  - datavalid=1 here -> overrun_err pulse, bit dropped; upstream must shift only on sm.
- PLOAD (1 cycle): p_en=1, t_en=0, p_cnt=0 -> PTX.
- PTX: t_en=1 for exactly K_N cycles; p_cnt increments each cycle.
  - p_cnt=K_N-1 -> DONE.
  - datavalid=1 -> overrun_err.
- DONE (1 cycle): done=1 -> IDLE; chunk reset to 0.
- start outside IDLE is ignored, with no error flag.
- start and rst together: rst wins.
- t_en=0 in every state except PTX, so message bits pass through the transmit mux while loading.
- Codeword length with continuous datavalid: 1 + NCHUNK*(LMLA+1) + 1 + K_N + 1 = 1287 cycles from the CLR cycle to the DONE cycle inclusive. Defaults: 1 + 1028 + 1 + 256 + 1.
- Counters never exceed their terminal values; no width overflow is possible at the defaults.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then 5 idle cycles -> ready=1, f_sel=0, all strobes 0, no overrun_err.
2. Nominal codeword: start pulse, then datavalid=1 continuously.
   - acc_clr one cycle after start.
   - en high at cycles 258, 515, 772, 1029 after the CLR cycle, with f_sel=0,1,2,3 respectively.
   - p_en at 1030; t_en high for exactly 256 cycles; done at 1287; ready=1 after.
3. Gapped input: datavalid toggled 1/0 every cycle -> first en only after 256 accepted bits (~512 cycles); sm=1 exactly on accepted bits; en count=4.
4. Protocol errors:
   - datavalid=1 in IDLE -> overrun_err pulse.
   - datavalid=1 during an ENC cycle -> overrun_err pulse, that bit not counted; next en delayed by one accepted bit.
   - start during PTX -> ignored; t_en run length remains 256.
5. Mid-operation reset: rst=1 during chunk 2 LOAD -> next cycle IDLE, ready=1, f_sel=0. A fresh start yields a full 4-chunk codeword with acc_clr asserted.
6. Back-to-back: start asserted in the cycle immediately after done -> second codeword runs with identical timing to scenario 2.
